// File: rtl/decoder_pkg.sv
// Shared constants and the binary-to-one-hot decode helper for decoder_stream.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FIFO_DEPTH, ERR_CNT_W, DEC_MAX_W, onehot_decode().
package decoder_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int ERR_CNT_W  = 8;
  // Widest one-hot word the helper can produce; callers slice what they need.
  localparam int DEC_MAX_W  = 256;

  // Returns {err, onehot[DEC_MAX_W-1:0]}. An out-of-range code yields err=1 and
  // an all-zero one-hot; otherwise exactly bit 'code' is set.
  function automatic logic [DEC_MAX_W:0] onehot_decode(input logic [31:0] code,
                                                       input logic [31:0] out_w);
    logic [DEC_MAX_W:0] v_res;
    v_res = '0;
    v_res[DEC_MAX_W] = (code >= out_w);
    for (int i = 0; i < DEC_MAX_W; i++) begin
      if ((code < out_w) && (code == 32'(i))) v_res[i] = 1'b1;
    end
    return v_res;
  endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Generic 2-entry valid/ready FIFO; head entry is always visible on o_out_dat.
// Latency: push at edge k shows at the output just after edge k when empty.
// Backpressure: i_in_rdy falls only when full; a pop re-opens it the next cycle.
// Ports: i_in_vld/o_in_rdy/i_in_dat (write side), o_out_vld/i_out_rdy/o_out_dat (read side).
module decoder_skid_buf
  import decoder_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_in_vld,
  output logic          o_in_rdy,
  input  logic [DW-1:0] i_in_dat,
  output logic          o_out_vld,
  input  logic          i_out_rdy,
  output logic [DW-1:0] o_out_dat
);

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  // Ready/valid decode only the count register, so no path from i_out_rdy to o_in_rdy.
  assign o_in_rdy  = (r_count != 2'(FIFO_DEPTH));
  assign o_out_vld = (r_count != 2'd0);
  assign w_push    = i_in_vld & o_in_rdy;
  assign w_pop     = o_out_vld & i_out_rdy;

  // Popped slots are cleared, so with the FIFO empty the head slot reads zero.
  assign o_out_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // Push and pop never target the same slot: an empty FIFO cannot pop and
      // a full one cannot push, so the two writes below never collide.
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_mem[r_rd_ptr] <= '0;
        r_rd_ptr        <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot decoder with a 2-entry buffer and error counting.
// Latency: a code pushed into an empty buffer at edge k is on out_* just after edge k.
// Backpressure: in_ready drops only with both entries held; 1 code/cycle when out_ready=1.
// Ports: in_valid/in_ready/in_code (codes in), out_valid/out_ready/out_onehot/out_err
// (decoded head), err_count (saturating count of accepted out-of-range codes).
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8   // legal: 2 <= OUT_W <= 2**IN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_onehot,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [DEC_MAX_W:0]   w_dec;
  logic [OUT_W:0]       w_push_dat;
  logic [OUT_W:0]       w_head_dat;
  logic                 w_push;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Decode before buffering so each entry already holds {err, onehot}.
  assign w_dec      = onehot_decode(32'(in_code), 32'(OUT_W));
  assign w_push_dat = {w_dec[DEC_MAX_W], w_dec[OUT_W-1:0]};
  assign w_push     = in_valid & in_ready;

  generate
    if (OUT_W < DEC_MAX_W) begin : g_dec_sink
      // Bits above OUT_W are always zero for this instance.
      logic w_unused_dec;
      assign w_unused_dec = ^w_dec[DEC_MAX_W-1:OUT_W];
    end
  endgenerate

  decoder_skid_buf #(
    .DW (OUT_W + 1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_in_vld  (in_valid),
    .o_in_rdy  (in_ready),
    .i_in_dat  (w_push_dat),
    .o_out_vld (out_valid),
    .i_out_rdy (out_ready),
    .o_out_dat (w_head_dat)
  );

  assign out_err    = w_head_dat[OUT_W];
  assign out_onehot = w_head_dat[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_push && w_push_dat[OUT_W] && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_decoder_stream.sv
module tb_decoder_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: defaults (IN_W=3, OUT_W=8)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [2:0] a_in_code;
  logic [7:0] a_out_onehot, a_err_count;
  // Instance B: OUT_W=6 so codes 6 and 7 are out of range
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [2:0] b_in_code;
  logic [5:0] b_out_onehot;
  logic [7:0] b_err_count;

  decoder_stream #(.IN_W(3), .OUT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_onehot(a_out_onehot), .out_err(a_out_err), .err_count(a_err_count)
  );

  decoder_stream #(.IN_W(3), .OUT_W(6)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_onehot(b_out_onehot), .out_err(b_out_err), .err_count(b_err_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Each row: expected outputs seen at this negedge, then inputs applied for the next edge.
  typedef struct {
    logic       vld;
    logic [2:0] code;
    logic       ordy;
    logic       e_irdy;
    logic       e_ovld;
    logic [7:0] e_oh;
    logic       e_err;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  function automatic vec_t mk(input logic vld, input logic [2:0] code, input logic ordy,
                              input logic e_irdy, input logic e_ovld,
                              input logic [7:0] e_oh, input logic e_err);
    vec_t v;
    v.vld = vld; v.code = code; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_oh = e_oh; v.e_err = e_err;
    return v;
  endfunction

  // Model for instance B
  logic [6:0] q[$];
  int         m_err_b;

  function automatic logic [6:0] dec6(input logic [2:0] code);
    logic [5:0] one;
    one = 6'b000001;
    if (code < 3'd6) return {1'b0, one << code};
    return 7'b1000000;
  endfunction

  task automatic rnd_step(input logic vld, input logic [2:0] code, input logic ordy);
    int sz;
    @(negedge clk);
    sz = q.size();
    check("rand in_ready", b_in_ready, (sz < 2));
    check("rand out_valid", b_out_valid, (sz != 0));
    if (sz != 0) begin
      check("rand head", {b_out_err, b_out_onehot}, q[0]);
      if (!q[0][6]) check("rand onehot bits", $countones(b_out_onehot), 1);
    end
    b_in_valid = vld; b_in_code = code; b_out_ready = ordy;
    if (ordy && sz != 0) void'(q.pop_front());
    if (vld && sz < 2) begin
      q.push_back(dec6(code));
      if (code >= 3'd6 && m_err_b < 255) m_err_b++;
    end
  endtask

  initial begin
    logic [2:0] xcode;
    xcode = 3'bxxx;
    // Streaming 0..7 with out_ready=1
    tv[0]  = mk(1, 3'd0, 1, 1, 0, 8'h00, 0);
    for (int i = 1; i < 8; i++) tv[i] = mk(1, 3'(i), 1, 1, 1, 8'(1 << (i - 1)), 0);
    tv[8]  = mk(0, 3'd0, 1, 1, 1, 8'h80, 0);
    tv[9]  = mk(0, 3'd0, 0, 1, 0, 8'h00, 0);
    // Backpressure: 3, 5, 6 with out_ready=0, then release
    tv[10] = mk(1, 3'd3, 0, 1, 0, 8'h00, 0);
    tv[11] = mk(1, 3'd5, 0, 1, 1, 8'h08, 0);
    tv[12] = mk(1, 3'd6, 0, 0, 1, 8'h08, 0);
    tv[13] = mk(1, 3'd6, 1, 0, 1, 8'h08, 0);
    tv[14] = mk(1, 3'd6, 1, 1, 1, 8'h20, 0);
    tv[15] = mk(0, 3'd0, 1, 1, 1, 8'h40, 0);
    // Unknown code with in_valid=0 must not be taken
    tv[16] = mk(0, xcode, 0, 1, 0, 8'h00, 0);
    tv[17] = mk(0, 3'd0, 0, 1, 0, 8'h00, 0);

    rst = 1'b1;
    a_in_valid = 0; a_in_code = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_code = 0; b_out_ready = 0;
    repeat (2) @(negedge clk);
    check("reset a out_valid", a_out_valid, 0);
    check("reset a in_ready", a_in_ready, 1);
    check("reset a onehot", a_out_onehot, 0);
    check("reset a err", a_out_err, 0);
    check("reset b err_count", b_err_count, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), a_in_ready, tv[i].e_irdy);
      check($sformatf("vec%0d out_valid", i), a_out_valid, tv[i].e_ovld);
      check($sformatf("vec%0d onehot", i), a_out_onehot, tv[i].e_oh);
      check($sformatf("vec%0d err", i), a_out_err, tv[i].e_err);
      a_in_valid = tv[i].vld; a_in_code = tv[i].code; a_out_ready = tv[i].ordy;
    end
    check("a err_count in-range only", a_err_count, 0);

    // Out-of-range on B: 6 then 7
    @(negedge clk); b_in_valid = 1; b_in_code = 3'd6; b_out_ready = 1;
    @(negedge clk);
    check("oor6 out_valid", b_out_valid, 1);
    check("oor6 onehot", b_out_onehot, 0);
    check("oor6 err", b_out_err, 1);
    b_in_code = 3'd7;
    @(negedge clk);
    check("oor7 onehot", b_out_onehot, 0);
    check("oor7 err", b_out_err, 1);
    check("oor err_count", b_err_count, 2);
    b_in_valid = 0;
    m_err_b = 2;

    // Saturation: 300 more out-of-range pushes
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      b_in_valid = 1; b_in_code = (i % 2 == 0) ? 3'd6 : 3'd7;
      if (m_err_b < 255) m_err_b++;
    end
    @(negedge clk); b_in_valid = 0;
    @(negedge clk);
    check("sat err_count", b_err_count, m_err_b);
    check("sat err_count ff", b_err_count, 8'hFF);
    b_in_valid = 1; b_in_code = 3'd5;
    @(negedge clk);
    check("sat in-range onehot", b_out_onehot, 6'h20);
    check("sat in-range err", b_out_err, 0);
    b_in_code = 3'd7;
    @(negedge clk);
    check("sat holds", b_err_count, 8'hFF);
    b_in_valid = 0;

    // Mid-stream reset with two entries buffered in A
    @(negedge clk); a_in_valid = 1; a_in_code = 3'd1; a_out_ready = 0;
                    b_in_valid = 1; b_in_code = 3'd7; b_out_ready = 0;
    @(negedge clk); a_in_code = 3'd2; b_in_code = 3'd1;
    @(negedge clk);
    check("pre-reset a full", {a_in_ready, a_out_valid}, 2'b01);
    rst = 1'b1;
    #1;
    check("async reset a out_valid", a_out_valid, 0);
    check("async reset a in_ready", a_in_ready, 1);
    check("async reset a onehot", a_out_onehot, 0);
    check("async reset b err_count", b_err_count, 0);
    check("async reset b out_valid", b_out_valid, 0);
    @(negedge clk);
    check("reset ignores push", a_out_valid, 0);
    a_in_valid = 0; a_out_ready = 1; b_in_valid = 0; b_out_ready = 1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post-reset a stale", {a_out_valid, a_out_err, a_out_onehot}, 0);
      check("post-reset b stale", {b_out_valid, b_out_err, b_out_onehot}, 0);
    end

    // Random traffic on B against the queue model
    q.delete();
    m_err_b = 0;
    for (int c = 0; c < 10000; c++)
      rnd_step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 4; c++) rnd_step(1'b0, 3'd0, 1'b1);
    check("rand drained", b_out_valid, 0);
    check("rand err_count", b_err_count, m_err_b);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
